// File: rtl/pr_timer_dev_pkg.sv
// ============================================================================
// pr_timer_dev_pkg : register offsets, CTRL fields and FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package pr_timer_dev_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CNT  = 2'd1,
    INT  = 2'd2
  } state_e;

  // Codes 10/11 are treated as one-shot.
  function automatic logic [1:0] eff_mode(input logic [3:0] ctrl);
    return (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) ? MODE_RELOAD : MODE_ONESHOT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pr_timer_dev.sv
// ============================================================================
// pr_timer_dev : bus-mapped programmable down-counter timer with IRQ output
// Rev 1.0
// ============================================================================
`default_nettype none

module pr_timer_dev
  import pr_timer_dev_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PrAddr,
  input  logic [31:0] PrWD,
  input  logic        PrWE,
  output logic [31:0] PrRD,
  output logic        IRQ
);

  logic [3:0]  ctrl_q,     ctrl_d;
  logic [31:0] preset_q,   preset_d;
  logic [31:0] count_q,    count_d;
  logic        irq_pend_q, irq_pend_d;
  logic        irq_q,      irq_d;
  state_e      state_q,    state_d;

  logic        sel;
  logic [1:0]  off;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        en;
  logic        reload;
  logic        hw_en_clr;
  logic        unused_addr_lsb;

  assign sel             = (PrAddr[31:4] == BASE_ADDR[31:4]);
  assign off             = PrAddr[3:2];
  assign ctrl_wr         = PrWE & sel & (off == OFF_CTRL);
  assign preset_wr       = PrWE & sel & (off == OFF_PRESET);
  assign en              = ctrl_q[CTRL_EN];
  assign reload          = (eff_mode(ctrl_q) == MODE_RELOAD);
  assign unused_addr_lsb = ^PrAddr[1:0];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    irq_pend_d = irq_pend_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_wr ? PrWD : preset_q;
    hw_en_clr  = 1'b0;

    // Any CTRL write acknowledges the pending interrupt; an expiry on the
    // same edge re-sets it below.
    if (ctrl_wr) begin
      irq_pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          count_d = preset_q;
          state_d = CNT;
        end
      end
      CNT: begin
        if (en) begin
          if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d    = 32'd0;
            irq_pend_d = 1'b1;
            state_d    = INT;
            hw_en_clr  = ~reload;
          end
        end
      end
      INT: begin
        if (reload && en) begin
          count_d    = preset_q;
          irq_pend_d = 1'b0;
          state_d    = CNT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Software write to CTRL takes priority over the one-shot EN clear.
    if (ctrl_wr) begin
      ctrl_d = PrWD[3:0];
    end else if (hw_en_clr) begin
      ctrl_d[CTRL_EN] = 1'b0;
    end

    irq_d = irq_pend_d & ctrl_d[CTRL_IM];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= IDLE;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    PrRD = 32'd0;
    if (sel) begin
      case (off)
        OFF_CTRL:   PrRD = {28'd0, ctrl_q};
        OFF_PRESET: PrRD = preset_q;
        OFF_COUNT:  PrRD = count_q;
        default:    PrRD = 32'd0;
      endcase
    end
  end

  assign IRQ = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_pr_timer_dev.sv
// Directed bench for pr_timer_dev: one task per scenario, inline checks.
`default_nettype none
`timescale 1ns/1ps

module tb_pr_timer_dev;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_UNMAP  = 32'h0000_7F0C;

  logic        clk;
  logic        reset;
  logic [31:0] PrAddr;
  logic [31:0] PrWD;
  logic        PrWE;
  logic [31:0] PrRD;
  logic        IRQ;

  int tests_run;
  int tests_failed;

  pr_timer_dev #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk    (clk),
    .reset  (reset),
    .PrAddr (PrAddr),
    .PrWD   (PrWD),
    .PrWE   (PrWE),
    .PrRD   (PrRD),
    .IRQ    (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    PrAddr = addr;
    PrWD   = data;
    PrWE   = 1'b1;
    @(posedge clk);
    #1;
    PrWE   = 1'b0;
    PrAddr = 32'd0;
    PrWD   = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    PrAddr = addr;
    #1;
    data   = PrRD;
    PrAddr = 32'd0;
  endtask

  task automatic do_reset();
    PrAddr = 32'd0;
    PrWD   = 32'd0;
    PrWE   = 1'b0;
    reset  = 1'b0;
    #2;
    reset  = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd0 || IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_init: count=%h irq=%b, want 0/0", v, IRQ);
    end
    #5 reset = 1'b1;
    bus_write(A_PRESET, 32'd10);
    bus_write(A_CTRL, 32'h9);
    tick(4);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd7) begin
      tests_failed++;
      $display("FAIL reset_precount: count=%0d, want 7", v);
    end
    #1 reset = 1'b0;
    #1;
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_async_count: count=%0d, want 0", v);
    end
    bus_read(A_CTRL, v);
    tests_run++;
    if (v !== 32'd0 || IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_async_ctrl: ctrl=%h irq=%b, want 0/0", v, IRQ);
    end
    reset = 1'b1;
    tick(1);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_release_count: count=%0d, want 0", v);
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRESET, 32'd5);
    bus_write(A_CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      bus_read(A_COUNT, v);
      tests_run++;
      if (v !== 32'(6 - k) || IRQ !== (k == 6)) begin
        tests_failed++;
        $display("FAIL oneshot_edge%0d: count=%0d irq=%b, want %0d/%b", k, v, IRQ, 6 - k, k == 6);
      end
    end
    tick(3);
    bus_read(A_CTRL, v);
    tests_run++;
    if (v !== 32'h8 || IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL oneshot_hold: ctrl=%h irq=%b, want 8/1", v, IRQ);
    end
    bus_write(A_CTRL, 32'h0);
    tests_run++;
    if (IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL oneshot_ack: irq=%b, want 0", IRQ);
    end
  endtask

  task automatic test_reload();
    logic [31:0] v;
    int idx;
    do_reset();
    bus_write(A_PRESET, 32'd3);
    bus_write(A_CTRL, 32'hB);
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      idx = (k - 1) % 4;
      bus_read(A_COUNT, v);
      tests_run++;
      if (v !== 32'(3 - idx) || IRQ !== (idx == 3)) begin
        tests_failed++;
        $display("FAIL reload_edge%0d: count=%0d irq=%b, want %0d/%b", k, v, IRQ, 3 - idx, idx == 3);
      end
    end
  endtask

  task automatic test_preset_midcount();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRESET, 32'd3);
    bus_write(A_CTRL, 32'hB);
    tick(1);
    bus_write(A_PRESET, 32'd6);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd2) begin
      tests_failed++;
      $display("FAIL preset_mid_nochange: count=%0d, want 2", v);
    end
    tick(2);
    tests_run++;
    if (IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL preset_mid_expire: irq=%b, want 1", IRQ);
    end
    tick(1);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd6 || IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL preset_mid_reload: count=%0d irq=%b, want 6/0", v, IRQ);
    end
  endtask

  task automatic test_short_preset();
    logic [31:0] v;
    do_reset();
    bus_write(A_CTRL, 32'h9);
    tick(1);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd0 || IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL preset0_load: count=%0d irq=%b, want 0/0", v, IRQ);
    end
    tick(1);
    tests_run++;
    if (IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL preset0_expire: irq=%b, want 1", IRQ);
    end
  endtask

  task automatic test_pause();
    logic [31:0] v;
    logic        held_ok;
    do_reset();
    bus_write(A_PRESET, 32'd8);
    bus_write(A_CTRL, 32'h9);
    tick(4);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd5) begin
      tests_failed++;
      $display("FAIL pause_pre: count=%0d, want 5", v);
    end
    bus_write(A_CTRL, 32'h8);
    held_ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus_read(A_COUNT, v);
      if (v !== 32'd4) held_ok = 1'b0;
      tick(1);
    end
    bus_read(A_COUNT, v);
    tests_run++;
    if (!held_ok || v !== 32'd4) begin
      tests_failed++;
      $display("FAIL pause_hold: count=%0d held=%b, want 4/1", v, held_ok);
    end
    bus_write(A_CTRL, 32'h9);
    tick(1);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd3 || IRQ !== 1'b0) begin
      tests_failed++;
      $display("FAIL pause_resume: count=%0d irq=%b, want 3/0", v, IRQ);
    end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRESET, 32'h1234);
    bus_write(32'h0000_7F10, 32'hFFFF_FFFF);
    bus_write(32'h0000_1000, 32'hFFFF_FFFF);
    bus_write(A_UNMAP, 32'hFFFF_FFFF);
    bus_read(32'h0000_7F10, v);
    tests_run++;
    if (v !== 32'd0) begin
      tests_failed++;
      $display("FAIL decode_nosel_rd: rd=%h, want 0", v);
    end
    bus_read(A_UNMAP, v);
    tests_run++;
    if (v !== 32'd0) begin
      tests_failed++;
      $display("FAIL decode_unmapped_rd: rd=%h, want 0", v);
    end
    bus_read(A_CTRL, v);
    tests_run++;
    if (v !== 32'd0) begin
      tests_failed++;
      $display("FAIL decode_ctrl: ctrl=%h, want 0", v);
    end
    bus_read(32'h0000_7F07, v);
    tests_run++;
    if (v !== 32'h1234) begin
      tests_failed++;
      $display("FAIL decode_preset: preset=%h, want 1234", v);
    end
    bus_write(A_CTRL, 32'h1);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_COUNT, 32'd0);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'h1234) begin
      tests_failed++;
      $display("FAIL decode_count_ro: count=%h, want 1234", v);
    end
  endtask

  task automatic test_collision();
    logic [31:0] v;
    do_reset();
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'h9);
    tick(2);
    bus_write(A_CTRL, 32'h9);
    bus_read(A_CTRL, v);
    tests_run++;
    if (v !== 32'h9 || IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL collide_edge: ctrl=%h irq=%b, want 9/1", v, IRQ);
    end
    tick(1);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd0 || IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL collide_idle: count=%0d irq=%b, want 0/1", v, IRQ);
    end
    tick(1);
    bus_read(A_COUNT, v);
    tests_run++;
    if (v !== 32'd2 || IRQ !== 1'b1) begin
      tests_failed++;
      $display("FAIL collide_reload: count=%0d irq=%b, want 2/1", v, IRQ);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b0;
    PrAddr = 32'd0;
    PrWD   = 32'd0;
    PrWE   = 1'b0;
    #1;
    test_reset();
    test_oneshot();
    test_reload();
    test_preset_midcount();
    test_short_preset();
    test_pause();
    test_decode();
    test_collision();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pr_timer_dev.md
Name: pr_timer_dev

Overview:
Programmable down-counter timer that sits as a responder on the processor bus (PrAddr/PrWD/PrWE/PrRD), at the far end from the CPU's memory stage. The CPU programs it with sw and reads it with lw to the device window. On expiry it raises a hardware interrupt line, which the system wires into one HWInt bit (HWInt[2] for timer 0). Two instances at different bases give two timers.

Parameters:
BASE_ADDR, 32'h0000_7F00, device window base; must be 16-byte aligned; decode uses PrAddr[31:4].

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
PrAddr  in  32  CPU bus address; 0 when the CPU is not addressing the device space
PrWD  in  32  CPU bus write data
PrWE  in  1  CPU bus write enable, one cycle per sw
PrRD  out  32  read data, combinational from registers; 0 when not selected
IRQ  out  1  registered interrupt request to HWInt

Behaviour:
- Select: sel = (PrAddr[31:4] == BASE_ADDR[31:4]). Word offset PrAddr[3:2]: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unmapped. PrAddr[1:0] is ignored.
- CTRL[3:0]:
  - bit0 EN.
  - bits2:1 MODE: 00 = one-shot; 01 = auto-reload; 10/11 behave as 00.
  - bit3 IM, the interrupt mask (1 = enabled).
  - CTRL[31:4] reads as 0.
- PRESET: 32-bit read/write. COUNT: 32-bit, read-only; writes to it are ignored. Offset 3 reads 0; writes to it are ignored.
- Write occurs on a clk edge with PrWE & sel. It updates the addressed register at that edge.
- Read: PrRD = sel ? register[offset] : 0, combinational with no added latency (the CPU samples it in the same cycle).
- Reset (reset low, asynchronous): CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq_pend = 0, IRQ = 0.
- State machine (state, irq_pend and COUNT registered):
  - IDLE: if EN, then COUNT <= PRESET and go to CNT. Otherwise hold.
  - CNT, EN = 0: freeze COUNT and stay in CNT (pause).
  - CNT, EN = 1, COUNT > 1: COUNT <= COUNT - 1.
  - CNT, EN = 1, COUNT <= 1: COUNT <= 0, irq_pend <= 1, go to INT. In MODE 00, the hardware also clears EN at this edge.
  - INT, MODE 01 with EN = 1: COUNT <= PRESET, irq_pend <= 0, go to CNT. The period is PRESET + 1 cycles.
  - INT, otherwise: go to IDLE. irq_pend stays set.
- irq_pend in one-shot mode is cleared only by a CTRL write. IRQ <= irq_pend_next & IM_next, registered.
- Latency: EN written at edge e0 with PRESET = N >= 1 gives COUNT = N after e1, reaches 1 after eN, and IRQ = 1 after e(N+1).
- Boundary cases:
  - PRESET = 0 or 1: expiry occurs at the edge after the load.
  - A PRESET write during CNT does not affect the current count; it takes effect at the next load.
  - Writing EN = 0 and then EN = 1 during CNT resumes from the frozen COUNT; it does not reload.
  - CTRL write in the same edge as expiry: the software-written CTRL value wins over the hardware EN clear, and the irq_pend set wins over the clear caused by the CTRL write.
  - A CTRL write that clears IM drops IRQ one edge later; irq_pend is unaffected by IM.
  - Reset asserted mid-count: everything returns to reset values immediately, with no pending IRQ.
- COUNT arithmetic is unsigned 32-bit. It never decrements below 0, so there is no wrap-around.

Decomposition:
- Shared package holds:
  - offset constants OFF_CTRL = 2'd0, OFF_PRESET = 2'd1, OFF_COUNT = 2'd2;
  - CTRL bit positions EN = 0, MODE = 2:1, IM = 3;
  - mode codes MODE_ONESHOT = 2'b00, MODE_RELOAD = 2'b01;
  - state encoding IDLE / CNT / INT (2 bits).
- No sub-module: register file, FSM and read mux form one block of about 150-200 lines.

Test Plan:
- Reset low mid-count (CTRL = 4'b1001, COUNT = 7) -> COUNT = 0, CTRL = 0, IRQ = 0 asynchronously. After release, PrRD at 0x7F08 = 0.
- Write PRESET = 5 at 0x7F04, then CTRL = 4'b1001 (one-shot, IM) at 0x7F00 -> COUNT reads 5, 4, 3, 2, 1, 0 on successive cycles. IRQ rises 6 edges after the CTRL write and stays high, and CTRL reads 4'b1000. Writing CTRL = 0 drops IRQ one edge later.
- PRESET = 3, CTRL = 4'b1011 (auto-reload) -> IRQ is a one-cycle pulse every 4 cycles. COUNT reads 3, 2, 1, 0, 3, ...
- Pause: during a count at COUNT = 4, write CTRL = 4'b1000 -> COUNT holds 4 for 10 cycles. Then write 4'b1001 -> counting resumes at 3 with no reload.
- Decode: PrAddr = 0x7F10 or 0x0000_1000 with PrWE = 1 and PrWD = 0xFFFF_FFFF -> no register changes and PrRD = 0. Reading 0x7F0C returns 0. A write to 0x7F08 leaves COUNT unchanged.
- Collision: with PRESET = 2, write CTRL = 4'b1001 on the exact expiry edge -> EN reads 1, irq_pend (and IRQ) = 1, and the FSM reloads on the following cycle via IDLE.
